// File: rtl/cic_pdm_decim.sv
// cic_pdm_decim
//   Multi-channel CIC decimator that turns 1-bit PDM streams into signed PCM.
//   Each channel has STAGES integrators running at the PDM strobe rate. Every
//   DECIMATION strobes the last integrator is snapshotted. The snapshot runs
//   through STAGES pipelined comb stages, then an arithmetic right shift, then
//   saturation to OUT_WIDTH. Results land in a single valid/ready holding
//   register.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   pdm_en     PDM sample strobe; pdm_in is consumed only when high
//   pdm_in     one PDM bit per channel (bit c = channel c); 1 -> +1, 0 -> -1
//   shift      right-shift applied to the comb output, latched at snapshot
//   pcm_data   packed signed samples, channel c at [c*OUT_WIDTH +: OUT_WIDTH]
//   pcm_valid  a frame is held in the output register
//   pcm_ready  downstream accepts the held frame
//   overrun    one-cycle pulse when a completed frame is dropped
//   sat        with pcm_valid: some channel of the held frame saturated

module cic_pdm_decim #(
  parameter int STAGES     = 3,
  parameter int DECIMATION = 64,
  parameter int CHANNELS   = 2,
  parameter int OUT_WIDTH  = 16,
  parameter int ACC_WIDTH  = STAGES * $clog2(DECIMATION) + 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pdm_en,
  input  logic [CHANNELS-1:0]             pdm_in,
  input  logic [4:0]                      shift,
  output logic [CHANNELS*OUT_WIDTH-1:0]   pcm_data,
  output logic                            pcm_valid,
  input  logic                            pcm_ready,
  output logic                            overrun,
  output logic                            sat
);

  localparam int CNT_W = $clog2(DECIMATION);
  localparam int EXT_W = (ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH;
  localparam logic signed [EXT_W-1:0] PCM_MAX = EXT_W'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] PCM_MIN = EXT_W'(-(2 ** (OUT_WIDTH - 1)));

  // ---------------------------------------------------------------------------
  // Integrators
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] integ     [CHANNELS][STAGES];
  logic [ACC_WIDTH-1:0] integ_nxt [CHANNELS][STAGES];
  logic [ACC_WIDTH-1:0] chain;

  // The cascade is chained combinationally within one strobe. The snapshot of
  // the last integrator therefore already contains the current strobe's
  // sample. Wrap-around is intentional: the combs recover the exact result
  // modulo 2^ACC_WIDTH.
  always_comb begin
    chain = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      chain = pdm_in[c] ? ACC_WIDTH'(1) : '1;
      for (int unsigned s = 0; s < STAGES; s++) begin
        chain           = integ[c][s] + chain;
        integ_nxt[c][s] = chain;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CHANNELS; c++)
        for (int unsigned s = 0; s < STAGES; s++)
          integ[c][s] <= '0;
    end else if (pdm_en) begin
      for (int unsigned c = 0; c < CHANNELS; c++)
        for (int unsigned s = 0; s < STAGES; s++)
          integ[c][s] <= integ_nxt[c][s];
    end
  end

  // ---------------------------------------------------------------------------
  // Decimation counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic             snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      snap <= 1'b0;
    end else begin
      snap <= pdm_en && (cnt == CNT_W'(DECIMATION - 1));
      if (pdm_en)
        cnt <= cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Comb pipeline: stage 0 is the snapshot, stages 1..STAGES are differences
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] comb_d    [CHANNELS][STAGES+1];
  logic [ACC_WIDTH-1:0] comb_prev [CHANNELS][STAGES];
  logic [STAGES:0]      comb_v;
  logic [4:0]           shift_lat;

  // One shift_lat register is enough. The pipeline from snapshot to output is
  // at most 8 cycles long, and the next snapshot is at least DECIMATION >= 8
  // cycles away, so a frame leaves the pipeline before the next one latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comb_v    <= '0;
      shift_lat <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        for (int unsigned k = 0; k <= STAGES; k++)
          comb_d[c][k] <= '0;
        for (int unsigned k = 0; k < STAGES; k++)
          comb_prev[c][k] <= '0;
      end
    end else begin
      comb_v <= {comb_v[STAGES-1:0], snap};
      if (snap) begin
        shift_lat <= shift;
        for (int unsigned c = 0; c < CHANNELS; c++)
          comb_d[c][0] <= integ[c][STAGES-1];
      end
      for (int unsigned k = 1; k <= STAGES; k++) begin
        if (comb_v[k-1]) begin
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            comb_d[c][k]      <= comb_d[c][k-1] - comb_prev[c][k-1];
            comb_prev[c][k-1] <= comb_d[c][k-1];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scaling and saturation
  // ---------------------------------------------------------------------------
  logic signed [EXT_W-1:0]          ext_v;
  logic signed [EXT_W-1:0]          shr_v;
  logic [CHANNELS*OUT_WIDTH-1:0]    pcm_next;
  logic                             frame_sat;

  // Sign-extend before shifting so that shifts >= ACC_WIDTH settle to 0 / -1.
  always_comb begin
    ext_v     = '0;
    shr_v     = '0;
    pcm_next  = '0;
    frame_sat = 1'b0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      ext_v = EXT_W'($signed(comb_d[c][STAGES]));
      shr_v = ext_v >>> shift_lat;
      if (shr_v > PCM_MAX) begin
        pcm_next[c*OUT_WIDTH +: OUT_WIDTH] = PCM_MAX[OUT_WIDTH-1:0];
        frame_sat = 1'b1;
      end else if (shr_v < PCM_MIN) begin
        pcm_next[c*OUT_WIDTH +: OUT_WIDTH] = PCM_MIN[OUT_WIDTH-1:0];
        frame_sat = 1'b1;
      end else begin
        pcm_next[c*OUT_WIDTH +: OUT_WIDTH] = shr_v[OUT_WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output holding register with valid/ready handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
      sat       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (comb_v[STAGES]) begin
        if (!pcm_valid || pcm_ready) begin
          pcm_data  <= pcm_next;
          sat       <= frame_sat;
          pcm_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (pcm_valid && pcm_ready) begin
        pcm_valid <= 1'b0;
        sat       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_pdm_decim.sv
// tb_cic_pdm_decim
//   Drives cic_pdm_decim with directed phases and a randomized phase.
//   Expected outputs come from a reference model inside the bench:
//   - a direct FIR convolution with the (box filter)^STAGES impulse response;
//   - floor shift and saturation;
//   - a frame-level model of the holding register.
//   DUT outputs are sampled 1 ns after each rising clock edge.

module tb_cic_pdm_decim;

  localparam int STAGES = 3;
  localparam int R      = 64;
  localparam int CH     = 2;
  localparam int OW     = 16;
  localparam int HL     = STAGES * (R - 1) + 1;
  localparam int MAXS   = 16384;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 pdm_en;
  logic [CH-1:0]        pdm_in;
  logic [4:0]           shift;
  logic [CH*OW-1:0]     pcm_data;
  logic                 pcm_valid;
  logic                 pcm_ready;
  logic                 overrun;
  logic                 sat;

  cic_pdm_decim #(
    .STAGES     (STAGES),
    .DECIMATION (R),
    .CHANNELS   (CH),
    .OUT_WIDTH  (OW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pdm_en    (pdm_en),
    .pdm_in    (pdm_in),
    .shift     (shift),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .overrun   (overrun),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              arrive;
    logic [CH*OW-1:0] data;
    logic            sat;
    bit              trans;
  } frame_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  longint  h   [HL];
  longint  tmp [HL];
  int      hist [CH][MAXS];
  int      nstr, scnt, fidx, cyc;
  bit      alt_bit;
  frame_t  pendq[$];
  bit      pend_cap;
  int      pend_cyc;
  longint  pend_y [CH];
  bit      m_valid, m_sat, m_trans, m_ovr;
  logic [CH*OW-1:0] m_data;

  // Stimulus modes
  int en_mode;          // 0 always, 1 one in four, 2 random, 3 off
  int bit_mode [CH];    // 0 zeros, 1 ones, 2 alternating, 3 random
  int rdy_mode;         // 0 low, 1 high, 2 random
  bit shift_rand;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint conv(int c, int n);
    longint y = 0;
    for (int j = 0; j < HL && j <= n; j++)
      y += h[j] * longint'(hist[c][n-j]);
    return y;
  endfunction

  function automatic logic [OW-1:0] scale(longint y, int s, output logic st);
    longint v, lmax, lmin;
    lmax = (longint'(1) << (OW - 1)) - 1;
    lmin = -lmax - 1;
    v  = y >>> s;
    st = 1'b0;
    if (v > lmax) begin
      v = lmax; st = 1'b1;
    end else if (v < lmin) begin
      v = lmin; st = 1'b1;
    end
    return v[OW-1:0];
  endfunction

  task automatic model_clear();
    nstr = 0; scnt = 0; fidx = 0;
    pendq.delete();
    pend_cap = 1'b0;
    m_valid = 1'b0; m_sat = 1'b0; m_trans = 1'b0; m_ovr = 1'b0;
    m_data = '0;
  endtask

  task automatic drive();
    case (en_mode)
      0:       pdm_en = 1'b1;
      1:       pdm_en = (cyc % 4 == 0);
      2:       pdm_en = 1'($urandom_range(0, 1));
      default: pdm_en = 1'b0;
    endcase
    for (int c = 0; c < CH; c++) begin
      case (bit_mode[c])
        0:       pdm_in[c] = 1'b0;
        1:       pdm_in[c] = 1'b1;
        2:       pdm_in[c] = alt_bit;
        default: pdm_in[c] = 1'($urandom_range(0, 1));
      endcase
    end
    case (rdy_mode)
      0:       pcm_ready = 1'b0;
      1:       pcm_ready = 1'b1;
      default: pcm_ready = 1'($urandom_range(0, 1));
    endcase
    if (shift_rand)
      shift = 5'($urandom_range(0, 24));
  endtask

  // One clock: update the model for the edge, compare, drive the next inputs.
  task automatic tick();
    frame_t f;
    logic   st;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      m_ovr = 1'b0;
      if (m_valid && pcm_ready)
        m_valid = 1'b0;
      if (pendq.size() > 0 && pendq[0].arrive == cyc) begin
        f = pendq.pop_front();
        if (m_valid) begin
          m_ovr = 1'b1;
        end else begin
          m_valid = 1'b1; m_data = f.data; m_sat = f.sat; m_trans = f.trans;
        end
      end
      if (pdm_en) begin
        if (nstr >= MAXS) begin
          $display("FAIL history: model storage exhausted");
          $fatal(1, "model storage exhausted");
        end
        for (int c = 0; c < CH; c++)
          hist[c][nstr] = pdm_in[c] ? 1 : -1;
        nstr++;
        alt_bit = ~alt_bit;
        scnt++;
        if (scnt == R) begin
          scnt = 0;
          for (int c = 0; c < CH; c++)
            pend_y[c] = conv(c, nstr - 1);
          pend_cap = 1'b1;
          pend_cyc = cyc;
        end
      end
    end
    #1;
    chk("valid", pcm_valid, m_valid);
    chk("overrun", overrun, m_ovr);
    if (m_valid && !m_trans) begin
      chk("data", pcm_data, m_data);
      chk("sat", sat, m_sat);
    end
    drive();
    // The frame's shift is the value on the input at the edge after the last
    // strobe, which is the one just driven.
    if (pend_cap) begin
      f.arrive = pend_cyc + STAGES + 2;
      f.sat    = 1'b0;
      f.data   = '0;
      for (int c = 0; c < CH; c++) begin
        f.data[c*OW +: OW] = scale(pend_y[c], int'(shift), st);
        f.sat = f.sat | st;
      end
      f.trans = (fidx < STAGES);
      fidx++;
      pendq.push_back(f);
      pend_cap = 1'b0;
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(string tag, int budget);
    int i = 0;
    while (!pcm_valid && i < budget) begin
      tick();
      i++;
    end
    chk(tag, pcm_valid, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < HL; i++) h[i] = 0;
    h[0] = 1;
    for (int s = 0; s < STAGES; s++) begin
      for (int i = 0; i < HL; i++) begin
        tmp[i] = 0;
        for (int k = 0; k < R && k <= i; k++) tmp[i] += h[i-k];
      end
      for (int i = 0; i < HL; i++) h[i] = tmp[i];
    end

    rst_n = 1'b0; pdm_en = 1'b0; pdm_in = '0; shift = 5'd0; pcm_ready = 1'b0;
    cyc = 0; alt_bit = 1'b1;
    en_mode = 3; bit_mode[0] = 0; bit_mode[1] = 0; rdy_mode = 0; shift_rand = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", pcm_valid, 1'b0);
    chk("rst_data", pcm_data, '0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_sat", sat, 1'b0);
    #2 rst_n = 1'b1;

    // ch0 all ones, ch1 all zeros, shift 8
    en_mode = 0; bit_mode[0] = 1; bit_mode[1] = 0; rdy_mode = 1; shift = 5'd8;
    run(8 * R);
    wait_valid("p1_seen", 200);
    chk("p1_data", pcm_data, {16'hFC00, 16'h0400});
    chk("p1_sat", sat, 1'b0);

    // alternating input, shift 0
    bit_mode[0] = 2; bit_mode[1] = 2; shift = 5'd0;
    run(6 * R);
    wait_valid("p2_seen", 200);
    chk("p2_data", pcm_data, '0);
    chk("p2_sat", sat, 1'b0);

    // saturation both directions
    bit_mode[0] = 1; bit_mode[1] = 1;
    run(5 * R);
    wait_valid("p3_seen", 200);
    chk("p3_pos", pcm_data, {16'h7FFF, 16'h7FFF});
    chk("p3_pos_sat", sat, 1'b1);
    bit_mode[0] = 0; bit_mode[1] = 0;
    run(5 * R);
    wait_valid("p3n_seen", 200);
    chk("p3_neg", pcm_data, {16'h8000, 16'h8000});
    chk("p3_neg_sat", sat, 1'b1);

    // backpressure with overruns
    bit_mode[0] = 1; bit_mode[1] = 1; shift = 5'd8;
    run(5 * R);
    wait_valid("p4_seen", 200);
    rdy_mode = 0; pcm_ready = 1'b0;
    run(150);
    chk("p4_held", pcm_data, {16'h0400, 16'h0400});
    rdy_mode = 1;
    run(3 * R);

    // sparse strobes, one cycle in four
    en_mode = 1;
    run(6 * 4 * R);
    wait_valid("p5_seen", 600);
    chk("p5_data", pcm_data, {16'h0400, 16'h0400});

    // asynchronous reset mid-frame with a frame held
    rdy_mode = 0; pcm_ready = 1'b0;
    run(100);
    chk("p6_pre_valid", pcm_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("p6_rst_valid", pcm_valid, 1'b0);
    chk("p6_rst_data", pcm_data, '0);
    chk("p6_rst_overrun", overrun, 1'b0);
    chk("p6_rst_sat", sat, 1'b0);
    model_clear();
    en_mode = 0; rdy_mode = 1;
    run(3);
    #2 rst_n = 1'b1;
    run(8 * R);
    wait_valid("p6_seen", 200);
    chk("p6_data", pcm_data, {16'h0400, 16'h0400});

    // randomized strobes, bits, ready and shift
    en_mode = 2; bit_mode[0] = 3; bit_mode[1] = 3; rdy_mode = 2; shift_rand = 1'b1;
    run(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
